spi_shift_register: RTL

Data-path stage directly downstream of the SPI slave-select/control block. It loads a parallel byte from the SPI data register on `send_data`, serialises it onto `mosi` on baud-generator drive edges, samples `miso` on sample edges, and presents the received byte when the control block pulses `receive_data`. It is active only while the control block holds `ss` low.

---
 rtl/spi_shift_register.sv | 129 ++++++++++++
 1 files changed

// File: rtl/spi_shift_register.sv
// SPI transmit/receive shift stage: parallel load, serialise on tx edges, sample on rx edges.
// Optional internal loopback of mosi into the sampler when SPI_SHIFT_LOOPBACK_EN is defined.
module spi_shift_register #(
  parameter int DATA_W = 8
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              ss,
  input  logic              send_data,
  input  logic              receive_data,
  input  logic              lsbfe,
  input  logic              cpha,
  input  logic              flag_tx_edge,
  input  logic              flag_rx_edge,
  input  logic [DATA_W-1:0] data_mosi,
  input  logic              miso,
  input  logic              loopback,
  output logic              mosi,
  output logic [DATA_W-1:0] data_miso,
  output logic              rx_valid,
  output logic              busy
);

  localparam int CW = $clog2(DATA_W) + 1;
  localparam int IW = $clog2(DATA_W);
  localparam logic [CW-1:0] FULL = CW'(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, ARMED, SHIFT, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic [CW-1:0]     tx_cnt;
  logic [CW-1:0]     rx_cnt;
  logic              lsbfe_q;
  logic              ss_q;
  logic              sample;
  logic              active;
  logic              ss_rise;
  logic              tx_go;
  logic              rx_go;
  logic [IW-1:0]     tx_idx;
  logic [IW-1:0]     rx_idx;
  logic [IW-1:0]     first_idx;

  // Map a transmit-order bit count onto a physical bit position of the word.
  function automatic logic [IW-1:0] order_idx(input logic lsb, input logic [CW-1:0] cnt);
    return lsb ? IW'(cnt) : IW'(LAST - cnt);
  endfunction

`ifdef SPI_SHIFT_LOOPBACK_EN
  assign sample = loopback ? mosi : miso;
`else
  logic unused_loopback;
  assign unused_loopback = loopback;
  assign sample = miso;
`endif

  assign busy = (state != IDLE);

  always_comb begin
    active    = (state == ARMED) || (state == SHIFT);
    ss_rise   = ss & ~ss_q;
    tx_go     = active & ~ss & flag_tx_edge & (tx_cnt < FULL);
    rx_go     = active & ~ss & flag_rx_edge & (rx_cnt < FULL);
    tx_idx    = order_idx(lsbfe_q, tx_cnt);
    rx_idx    = order_idx(lsbfe_q, rx_cnt);
    first_idx = lsbfe ? '0 : IW'(DATA_W - 1);
  end

  // cpha only changes what happens at load time, so it is not kept after the load edge.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= IDLE;
      tx_sh     <= '0;
      rx_sh     <= '0;
      tx_cnt    <= '0;
      rx_cnt    <= '0;
      lsbfe_q   <= 1'b0;
      ss_q      <= 1'b1;
      mosi      <= 1'b0;
      data_miso <= '0;
      rx_valid  <= 1'b0;
    end else begin
      ss_q     <= ss;
      rx_valid <= receive_data;
      if (receive_data)
        data_miso <= rx_sh;

      if (send_data) begin
        tx_sh   <= data_mosi;
        rx_sh   <= '0;
        lsbfe_q <= lsbfe;
        rx_cnt  <= '0;
        state   <= ARMED;
        if (!cpha) begin
          mosi   <= data_mosi[first_idx];
          tx_cnt <= CW'(1);
        end else begin
          tx_cnt <= '0;
        end
      end else if (state == DONE) begin
        if (receive_data)
          state <= IDLE;
      end else if (active) begin
        if (ss_rise) begin
          state  <= IDLE;
          tx_cnt <= '0;
          rx_cnt <= '0;
        end else begin
          if (tx_go) begin
            mosi   <= tx_sh[tx_idx];
            tx_cnt <= tx_cnt + 1'b1;
          end
          if (rx_go) begin
            rx_sh[rx_idx] <= sample;
            rx_cnt        <= rx_cnt + 1'b1;
          end
          if (rx_go && (rx_cnt == LAST))
            state <= DONE;
          else if ((state == ARMED) && !ss && (flag_tx_edge || flag_rx_edge))
            state <= SHIFT;
        end
      end
    end
  end

endmodule
